// File: rtl/mem_responder_pkg.sv
// Shared types and sizes for the memory responder.
package mem_responder_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BADDR_W = 32;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Request payload captured at acceptance
   typedef struct packed {
      logic               we;
      logic [BADDR_W-1:0] addr;
      logic [DATA_W-1:0]  wdata;
   } req_t;

endpackage

// File: rtl/mem_responder_array.sv
// Word array: synchronous write with enable, combinational read by word index.
module mem_array
   import mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] idx,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time with LATENCY wait states.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LATENCY    = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_we,
   input  logic [BADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0]  req_wdata,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [DATA_W-1:0]  resp_rdata,
   output logic               resp_err
);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   req_t              req_q, req_nxt, req_in, acc;
   logic              acc_err, do_access, mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic              resp_valid_nxt, resp_err_nxt;
   logic [DATA_W-1:0] resp_rdata_nxt;

   // Misaligned or beyond the array (full 32-bit check, no wrap)
   function automatic logic addr_err(input logic [BADDR_W-1:0] a);
      return (a[1:0] != 2'b00) || (a[BADDR_W-1:ADDR_WIDTH+2] != '0);
   endfunction

   assign req_ready = (state == S_IDLE);

   // Live request bundle; with zero latency the access uses it directly
   always_comb begin : req_sel
      req_in = '{we: req_we, addr: req_addr, wdata: req_wdata};
      acc    = ((LATENCY == 0) && (state == S_IDLE)) ? req_in : req_q;
   end

   assign acc_err = addr_err(acc.addr);
   // Reset blocks the write so a pending access is discarded
   assign mem_we  = do_access & acc.we & ~acc_err & ~reset;

   mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
      .clk   (clk),
      .we    (mem_we),
      .idx   (acc.addr[ADDR_WIDTH+1:2]),
      .wdata (acc.wdata),
      .rdata (mem_rdata)
   );

   // Next-state, counter, latch and response logic
   always_comb begin : fsm_comb
      state_nxt      = state;
      cnt_nxt        = cnt;
      req_nxt        = req_q;
      do_access      = 1'b0;
      resp_valid_nxt = resp_valid;
      resp_rdata_nxt = resp_rdata;
      resp_err_nxt   = resp_err;

      case (state)
         S_IDLE: begin
            if (req_valid) begin
               req_nxt = req_in;
               cnt_nxt = CNT_W'(LATENCY);
               if (LATENCY == 0) begin
                  do_access = 1'b1;
                  state_nxt = S_RESP;
               end else begin
                  state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) begin
               cnt_nxt   = '0;
               do_access = 1'b1;
               state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_nxt      = S_IDLE;
               resp_valid_nxt = 1'b0;
               resp_rdata_nxt = '0;
               resp_err_nxt   = 1'b0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      if (do_access) begin
         resp_valid_nxt = 1'b1;
         resp_err_nxt   = acc_err;
         resp_rdata_nxt = (!acc_err && !acc.we) ? mem_rdata : '0;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         req_q      <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         req_q      <= req_nxt;
         resp_valid <= resp_valid_nxt;
         resp_rdata <= resp_rdata_nxt;
         resp_err   <= resp_err_nxt;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders (LATENCY 2, 3, 0) against a scoreboard.
module tb_mem_responder;

   localparam int NDUT = 3;
   localparam int unsigned LAT [NDUT] = '{2, 3, 0};

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NDUT-1:0] reset, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
   logic [31:0]     req_addr [NDUT];
   logic [31:0]     req_wdata [NDUT];
   logic [31:0]     resp_rdata [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT[g])) u_dut (
         .clk        (clk),
         .reset      (reset[g]),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_we     (req_we[g]),
         .req_addr   (req_addr[g]),
         .req_wdata  (req_wdata[g]),
         .resp_valid (resp_valid[g]),
         .resp_ready (resp_ready[g]),
         .resp_rdata (resp_rdata[g]),
         .resp_err   (resp_err[g])
      );
   end

   int          checks = 0;
   int          failures = 0;
   exp_t        sb [$];
   logic [31:0] model [int];
   logic [31:0] b2b_addr [6];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic exp_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
   endfunction

   // Reference model: compute the expected response when the request is issued
   task automatic push_exp(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      exp_t e;
      int   key;
      e.err   = exp_err(addr);
      e.lat   = int'(LAT[d]);
      e.rdata = 32'h0;
      key     = d * 4096 + int'(addr[11:2]);
      if (!e.err) begin
         if (we) model[key] = wdata;
         else if (model.exists(key)) e.rdata = model[key];
      end
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input int d, input int lat_seen, input string tag, output exp_t e);
      e = '{rdata: 32'h0, err: 1'b0, lat: 0};
      check_eq({tag, " sb_empty"}, 32'(sb.size() == 0), 32'h0);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check_eq({tag, " rdata"}, resp_rdata[d], e.rdata);
      check_eq({tag, " err"}, 32'(resp_err[d]), 32'(e.err));
      if (lat_seen >= 0) check_eq({tag, " latency"}, 32'(lat_seen), 32'(e.lat));
   endtask

   // One full transaction; optionally stall resp_ready for 'hold' cycles
   task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold, input string tag);
      bit   ok;
      int   k;
      exp_t e;
      push_exp(d, we, addr, wdata);
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (req_ready[d]) begin
            ok = 1'b1;
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      req_valid[d] = 1'b0;
      check_eq({tag, " accept"}, 32'(ok), 32'h1);
      if (!ok) begin
         void'(sb.pop_back());
         return;
      end
      k = 0;
      while (!resp_valid[d] && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      pop_cmp(d, k, tag, e);
      for (int h = 0; h < hold; h++) begin
         if (h == 1) begin
            req_valid[d] = 1'b1;
            req_we[d]    = 1'b1;
            req_addr[d]  = 32'h40;
            req_wdata[d] = 32'h5555_5555;
         end
         @(posedge clk); #1;
         req_valid[d] = 1'b0;
         check_eq({tag, " hold valid"}, 32'(resp_valid[d]), 32'h1);
         check_eq({tag, " hold rdata"}, resp_rdata[d], e.rdata);
         check_eq({tag, " hold ready"}, 32'(req_ready[d]), 32'h0);
      end
      resp_ready[d] = 1'b1;
      @(posedge clk); #1;
      resp_ready[d] = 1'b0;
      check_eq({tag, " done valid"}, 32'(resp_valid[d]), 32'h0);
      check_eq({tag, " done rdata"}, resp_rdata[d], 32'h0);
      check_eq({tag, " done err"}, 32'(resp_err[d]), 32'h0);
      check_eq({tag, " done ready"}, 32'(req_ready[d]), 32'h1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   i, nresp, last;
      bit   rdy;
      exp_t e;

      reset      = '1;
      req_valid  = '0;
      req_we     = '0;
      resp_ready = '0;
      for (int d = 0; d < NDUT; d++) begin
         req_addr[d]  = 32'h0;
         req_wdata[d] = 32'h0;
      end
      repeat (2) @(posedge clk);
      #1;
      reset = '0;
      for (int d = 0; d < NDUT; d++) begin
         check_eq($sformatf("reset%0d ready", d), 32'(req_ready[d]), 32'h1);
         check_eq($sformatf("reset%0d valid", d), 32'(resp_valid[d]), 32'h0);
         check_eq($sformatf("reset%0d rdata", d), resp_rdata[d], 32'h0);
         check_eq($sformatf("reset%0d err", d), 32'(resp_err[d]), 32'h0);
      end

      // LATENCY=2: write then read back
      do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, "wr10");
      do_req(0, 1'b0, 32'h10, 32'h0, 0, "rd10");
      do_req(0, 1'b1, 32'h40, 32'h1111_1111, 0, "wr40");

      // Address errors and range boundaries
      do_req(0, 1'b0, 32'h13, 32'h0, 0, "rd_mis");
      do_req(0, 1'b0, 32'h0001_0000, 32'h0, 0, "rd_oor");
      do_req(0, 1'b1, 32'h11, 32'hFFFF_FFFF, 0, "wr_mis");
      do_req(0, 1'b1, 32'h8000_0010, 32'h1234_5678, 0, "wr_hi");
      do_req(0, 1'b1, 32'hFFC, 32'hCAFE_F00D, 0, "wr_top");
      do_req(0, 1'b0, 32'hFFC, 32'h0, 0, "rd_top");
      do_req(0, 1'b0, 32'h1000, 32'h0, 0, "rd_edge");
      do_req(0, 1'b0, 32'h10, 32'h0, 0, "rd10_again");

      // Stall in RESP with an ignored request pulse, then confirm 0x40 untouched
      do_req(0, 1'b0, 32'h10, 32'h0, 5, "hold");
      do_req(0, 1'b0, 32'h40, 32'h0, 0, "rd40");

      // LATENCY=3: reset during WAIT discards the write
      do_req(1, 1'b1, 32'h20, 32'hA5A5_A5A5, 0, "wr20");
      check_eq("rst_wr ready", 32'(req_ready[1]), 32'h1);
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b1;
      req_addr[1]  = 32'h20;
      req_wdata[1] = 32'h0BAD_0BAD;
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      check_eq("rst_wr accepted", 32'(req_ready[1]), 32'h0);
      @(posedge clk); #1;
      reset[1] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset[1] = 1'b0;
      check_eq("rst_wr valid", 32'(resp_valid[1]), 32'h0);
      check_eq("rst_wr ready_after", 32'(req_ready[1]), 32'h1);
      do_req(1, 1'b0, 32'h20, 32'h0, 0, "rd20");

      // LATENCY=0: preload, then back-to-back reads with resp_ready tied high
      for (int n = 0; n < 4; n++) begin
         do_req(2, 1'b1, 32'(n * 4), 32'h1000_0000 + 32'(n * 32'h0101_0101), 0, "wr_l0");
      end
      b2b_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h13, 32'h4};
      i = 0;
      nresp = 0;
      last = -1;
      resp_ready[2] = 1'b1;
      req_valid[2]  = 1'b1;
      req_we[2]     = 1'b0;
      req_addr[2]   = b2b_addr[0];
      for (int cyc = 0; cyc < 40 && nresp < 6; cyc++) begin
         rdy = req_ready[2];
         @(posedge clk); #1;
         if (rdy && i < 6) begin
            push_exp(2, 1'b0, b2b_addr[i], 32'h0);
            i++;
            if (i < 6) req_addr[2] = b2b_addr[i];
            else req_valid[2] = 1'b0;
         end
         if (resp_valid[2]) begin
            pop_cmp(2, -1, "b2b", e);
            if (last >= 0) check_eq("b2b spacing", 32'(cyc - last), 32'h2);
            last = cyc;
            nresp++;
         end
      end
      req_valid[2]  = 1'b0;
      resp_ready[2] = 1'b0;
      check_eq("b2b count", 32'(nresp), 32'h6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
